hazard_ctrl: RTL

Parametrised pipeline hazard controller for the 5-stage RV32I core, successor to the fixed non-forwarding unit. Generates PC/IF-ID/ID-EX/EX-MEM/MEM-WB write-enables and clears, ID/EX operand-forwarding selects, and a freeze for multi-cycle SRAM data accesses with a watchdog. It also keeps saturating stall/flush performance counters. Sits beside the datapath; all pipeline-register controls come from here.

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/hazard_sat_cnt.sv | 25 ++
 rtl/hazard_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the RV32I pipeline hazard controller: forward-select
// encoding, controller FSM states and the stage-control bundle.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } hz_state_e;

    typedef struct packed {
        logic pc_wren;
        logic ifid_wren;
        logic idex_wren;
        logic exmem_wren;
        logic memwb_wren;
        logic ifid_clear;
        logic idex_clear;
        logic exmem_clear;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_RUN    = 8'b1111_1000;
    localparam stage_ctrl_t CTRL_HALT   = 8'b0000_0000;
    localparam stage_ctrl_t CTRL_FLUSH  = 8'b1111_1111;
    localparam stage_ctrl_t CTRL_BUBBLE = 8'b0011_1010;

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter used for the stall and flush performance counters.
module hazard_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MAX = {W{1'b1}};

    // Count events, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: stage enables/clears,
// operand forwarding, memory-wait freeze with watchdog and perf counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned FWD_EN      = 1,
    parameter int unsigned RF_WT       = 1,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [REG_AW-1:0] i_ifid_rs1,
    input  logic [REG_AW-1:0] i_ifid_rs2,
    input  logic              i_ifid_rs1_used,
    input  logic              i_ifid_rs2_used,
    input  logic [REG_AW-1:0] i_idex_rs1,
    input  logic [REG_AW-1:0] i_idex_rs2,
    input  logic [REG_AW-1:0] i_idex_rd,
    input  logic              i_idex_rdwren,
    input  logic              i_idex_is_load,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic              i_exmem_rdwren,
    input  logic              i_exmem_is_load,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic              i_memwb_rdwren,
    input  logic              i_exmem_pcsel,
    input  logic              i_exmem_is_br,
    input  logic              i_exmem_is_uncbr,
    input  logic              i_lsu_req,
    input  logic              i_lsu_ack,
    output logic              o_pc_wren,
    output logic              o_ifid_wren,
    output logic              o_idex_wren,
    output logic              o_exmem_wren,
    output logic              o_memwb_wren,
    output logic              o_ifid_clear,
    output logic              o_idex_clear,
    output logic              o_exmem_clear,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic              o_mem_err,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WAIT_ONE  = WC_W'(1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

    // x0 is hardwired zero, so it can never be a producer.
    function automatic logic reg_match(input logic [REG_AW-1:0] rs, input logic used,
                                       input logic [REG_AW-1:0] rd, input logic wr);
        return used && wr && (rd != '0) && (rd == rs);
    endfunction

    hz_state_e         state_r, state_nxt_s;
    logic [WC_W-1:0]   wait_cnt_r, wait_cnt_nxt_s;
    logic              mem_err_r;
    logic              freeze_s, redirect_s, raw_s;
    logic              exmem_fwd_ok_s, stall_inc_s, flush_inc_s;
    stage_ctrl_t       ctrl_s;
    fwd_sel_e          fwd_a_s, fwd_b_s;

    assign freeze_s       = i_lsu_req && !i_lsu_ack;
    assign redirect_s     = i_exmem_pcsel && (i_exmem_is_br || i_exmem_is_uncbr);
    assign exmem_fwd_ok_s = i_exmem_rdwren && !i_exmem_is_load;

    // RAW detection: load-use only with bypassing, any in-flight producer without.
    always_comb begin
        raw_s = 1'b0;
        if (FWD_EN != 32'd0) begin
            raw_s = i_idex_is_load &&
                    (reg_match(i_ifid_rs1, i_ifid_rs1_used, i_idex_rd, i_idex_rdwren) ||
                     reg_match(i_ifid_rs2, i_ifid_rs2_used, i_idex_rd, i_idex_rdwren));
        end else begin
            raw_s = reg_match(i_ifid_rs1, i_ifid_rs1_used, i_idex_rd,  i_idex_rdwren)  ||
                    reg_match(i_ifid_rs2, i_ifid_rs2_used, i_idex_rd,  i_idex_rdwren)  ||
                    reg_match(i_ifid_rs1, i_ifid_rs1_used, i_exmem_rd, i_exmem_rdwren) ||
                    reg_match(i_ifid_rs2, i_ifid_rs2_used, i_exmem_rd, i_exmem_rdwren) ||
                    ((RF_WT == 32'd0) &&
                     (reg_match(i_ifid_rs1, i_ifid_rs1_used, i_memwb_rd, i_memwb_rdwren) ||
                      reg_match(i_ifid_rs2, i_ifid_rs2_used, i_memwb_rd, i_memwb_rdwren)));
        end
    end

    // Memory-wait FSM next state and watchdog counter.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        case (state_r)
            RUN: begin
                if (freeze_s) begin
                    state_nxt_s    = MEM_WAIT;
                    wait_cnt_nxt_s = WAIT_ONE;
                end else begin
                    state_nxt_s    = RUN;
                end
            end
            MEM_WAIT: begin
                if (!freeze_s) begin
                    state_nxt_s = RUN;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_nxt_s = ERR;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
                end
            end
            ERR:     state_nxt_s = ERR;
            default: state_nxt_s = RUN;
        endcase
    end

    // FSM, watchdog and sticky error registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= RUN;
            wait_cnt_r <= '0;
            mem_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            mem_err_r  <= mem_err_r || (state_nxt_s == ERR);
        end
    end

    // Prioritised stage controls; a held reset shows the run pattern.
    always_comb begin
        ctrl_s = CTRL_RUN;
        if (!i_rst_n) begin
            ctrl_s = CTRL_RUN;
        end else if (state_r == ERR) begin
            ctrl_s = CTRL_HALT;
        end else if (freeze_s) begin
            ctrl_s = CTRL_HALT;
        end else if (redirect_s) begin
            ctrl_s = CTRL_FLUSH;
        end else if (raw_s) begin
            ctrl_s = CTRL_BUBBLE;
        end else begin
            ctrl_s = CTRL_RUN;
        end
    end

    // Operand bypass selects; EX/MEM wins over MEM/WB as the younger producer.
    always_comb begin
        fwd_a_s = FWD_RF;
        fwd_b_s = FWD_RF;
        if (!i_rst_n || (FWD_EN == 32'd0)) begin
            fwd_a_s = FWD_RF;
            fwd_b_s = FWD_RF;
        end else begin
            if (reg_match(i_idex_rs1, 1'b1, i_exmem_rd, exmem_fwd_ok_s)) begin
                fwd_a_s = FWD_EXMEM;
            end else if (reg_match(i_idex_rs1, 1'b1, i_memwb_rd, i_memwb_rdwren)) begin
                fwd_a_s = FWD_MEMWB;
            end else begin
                fwd_a_s = FWD_RF;
            end
            if (reg_match(i_idex_rs2, 1'b1, i_exmem_rd, exmem_fwd_ok_s)) begin
                fwd_b_s = FWD_EXMEM;
            end else if (reg_match(i_idex_rs2, 1'b1, i_memwb_rd, i_memwb_rdwren)) begin
                fwd_b_s = FWD_MEMWB;
            end else begin
                fwd_b_s = FWD_RF;
            end
        end
    end

    assign stall_inc_s = (state_r != ERR) && (freeze_s || raw_s);
    assign flush_inc_s = (state_r != ERR) && redirect_s && !freeze_s;

    hazard_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (stall_inc_s),
        .count (o_stall_cnt)
    );

    hazard_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (flush_inc_s),
        .count (o_flush_cnt)
    );

    assign o_pc_wren     = ctrl_s.pc_wren;
    assign o_ifid_wren   = ctrl_s.ifid_wren;
    assign o_idex_wren   = ctrl_s.idex_wren;
    assign o_exmem_wren  = ctrl_s.exmem_wren;
    assign o_memwb_wren  = ctrl_s.memwb_wren;
    assign o_ifid_clear  = ctrl_s.ifid_clear;
    assign o_idex_clear  = ctrl_s.idex_clear;
    assign o_exmem_clear = ctrl_s.exmem_clear;
    assign o_fwd_a       = fwd_a_s;
    assign o_fwd_b       = fwd_b_s;
    assign o_mem_err     = mem_err_r;

endmodule
